// File: rtl/uart_pi_arb_pkg.sv
// Shared types for the UART processor-interface arbiter: FSM encoding,
// latched command layout and the gap-counter limits.
package uart_pi_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2,
    ST_GAP   = 2'd3
  } state_e;

  localparam int unsigned GAP_MAX = 15;
  localparam int unsigned GAP_W   = 4;

  // Command as captured at grant time; owner selects the completion port.
  typedef struct packed {
    logic       we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic       owner;
  } cmd_t;

endpackage

// File: rtl/uart_rr_arb2.sv
// Two-way round-robin picker. On a tie the requester that did not own the
// previous access wins; a lone requester always wins. Purely combinational.
module uart_rr_arb2
  import uart_pi_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_owner_i,
  output logic [1:0] gnt_o,
  output logic       gnt_idx_o
);

  always_comb begin
    gnt_idx_o = 1'b0;
    gnt_o     = 2'b00;
    unique case (req_i)
      2'b01:   gnt_idx_o = 1'b0;
      2'b10:   gnt_idx_o = 1'b1;
      2'b11:   gnt_idx_o = ~last_owner_i;
      default: gnt_idx_o = 1'b0;
    endcase
    if (req_i != 2'b00) gnt_o = gnt_idx_o ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/uart_pi_arb.sv
// Round-robin sequencer turning two valid/ready command streams into single
// cycle pi_* accesses, returning read data / write completion to the issuer.
module uart_pi_arb
  import uart_pi_arb_pkg::*;
#(
  parameter int unsigned GAP_CYCLES = 0
) (
  input  logic       clk,
  input  logic       rst,

  input  logic       req0_valid,
  input  logic       req0_we,
  input  logic [3:0] req0_addr,
  input  logic [7:0] req0_wdata,
  output logic       req0_ready,
  output logic       req0_rvalid,
  output logic [7:0] req0_rdata,

  input  logic       req1_valid,
  input  logic       req1_we,
  input  logic [3:0] req1_addr,
  input  logic [7:0] req1_wdata,
  output logic       req1_ready,
  output logic       req1_rvalid,
  output logic [7:0] req1_rdata,

  output logic       pi_blk_sel,
  output logic [3:0] pi_addr,
  output logic       pi_wr_en,
  output logic       pi_rd_en,
  output logic [7:0] pi_wr_data,
  input  logic [7:0] pi_rd_data
);

  if (GAP_CYCLES > GAP_MAX) begin : g_gap_range
    $error("uart_pi_arb: GAP_CYCLES must be in 0..15");
  end

  state_e             state_q;
  cmd_t               cmd_q, cmd_d;
  logic               last_owner_q;
  logic [GAP_W-1:0]   gap_cnt_q;
  logic [1:0]         rvalid_q;
  logic [7:0]         rdata0_q, rdata1_q;
  logic [7:0]         rdata_d;
  logic               blk_sel_q, wr_en_q, rd_en_q;
  logic [3:0]         addr_q;
  logic [7:0]         wr_data_q;

  logic [1:0]         gnt;
  logic               gnt_idx;
  logic               grant_en;

  uart_rr_arb2 u_rr (
    .req_i        ({req1_valid, req0_valid}),
    .last_owner_i (last_owner_q),
    .gnt_o        (gnt),
    .gnt_idx_o    (gnt_idx)
  );

  // Ready is combinational so a command is accepted in the same cycle it is
  // granted; it is masked during reset so nothing slips in on the reset edge.
  assign grant_en   = (state_q == ST_IDLE) && !rst;
  assign req0_ready = grant_en & gnt[0];
  assign req1_ready = grant_en & gnt[1];

  always_comb begin
    cmd_d = '{we: req0_we, addr: req0_addr, wdata: req0_wdata, owner: 1'b0};
    if (gnt_idx) cmd_d = '{we: req1_we, addr: req1_addr, wdata: req1_wdata, owner: 1'b1};
  end

  // Writes complete with zero data so the requester never sees stale bus values.
  assign rdata_d = cmd_q.we ? 8'h00 : pi_rd_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cmd_q        <= '0;
      last_owner_q <= 1'b1;
      gap_cnt_q    <= '0;
      rvalid_q     <= 2'b00;
      rdata0_q     <= 8'h00;
      rdata1_q     <= 8'h00;
      blk_sel_q    <= 1'b0;
      wr_en_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      addr_q       <= 4'h0;
      wr_data_q    <= 8'h00;
    end else begin
      rvalid_q <= 2'b00;
      unique case (state_q)
        ST_IDLE: begin
          if (grant_en && (gnt != 2'b00)) begin
            cmd_q     <= cmd_d;
            blk_sel_q <= 1'b1;
            addr_q    <= cmd_d.addr;
            wr_data_q <= cmd_d.wdata;
            wr_en_q   <= cmd_d.we;
            rd_en_q   <= ~cmd_d.we;
            state_q   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          blk_sel_q <= 1'b0;
          wr_en_q   <= 1'b0;
          rd_en_q   <= 1'b0;
          addr_q    <= 4'h0;
          wr_data_q <= 8'h00;
          rvalid_q[cmd_q.owner] <= 1'b1;
          if (cmd_q.owner) rdata1_q <= rdata_d;
          else             rdata0_q <= rdata_d;
          state_q <= ST_RESP;
        end
        ST_RESP: begin
          last_owner_q <= cmd_q.owner;
          if (GAP_CYCLES != 0) begin
            gap_cnt_q <= GAP_W'(GAP_CYCLES);
            state_q   <= ST_GAP;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_GAP: begin
          if (gap_cnt_q <= GAP_W'(1)) begin
            gap_cnt_q <= '0;
            state_q   <= ST_IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q - GAP_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req0_rvalid = rvalid_q[0];
  assign req1_rvalid = rvalid_q[1];
  assign req0_rdata  = rdata0_q;
  assign req1_rdata  = rdata1_q;
  assign pi_blk_sel  = blk_sel_q;
  assign pi_addr     = addr_q;
  assign pi_wr_en    = wr_en_q;
  assign pi_rd_en    = rd_en_q;
  assign pi_wr_data  = wr_data_q;

endmodule

// File: tb/tb_uart_pi_arb.sv
// Scoreboard bench for uart_pi_arb: one instance without gap for the main
// traffic, a second with GAP_CYCLES=4 for access spacing.
module tb_uart_pi_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       req0_valid, req0_we, req1_valid, req1_we;
  logic [3:0] req0_addr, req1_addr;
  logic [7:0] req0_wdata, req1_wdata;
  logic       req0_ready, req0_rvalid, req1_ready, req1_rvalid;
  logic [7:0] req0_rdata, req1_rdata;
  logic       pi_blk_sel, pi_wr_en, pi_rd_en;
  logic [3:0] pi_addr;
  logic [7:0] pi_wr_data, pi_rd_data;

  logic       b_req0_valid, b_req0_we, b_req1_valid, b_req1_we;
  logic [3:0] b_req0_addr, b_req1_addr;
  logic [7:0] b_req0_wdata, b_req1_wdata;
  logic       b_req0_ready, b_req0_rvalid, b_req1_ready, b_req1_rvalid;
  logic [7:0] b_req0_rdata, b_req1_rdata;
  logic       b_pi_blk_sel, b_pi_wr_en, b_pi_rd_en;
  logic [3:0] b_pi_addr;
  logic [7:0] b_pi_wr_data, b_pi_rd_data;

  // UART register block stand-in: read data is 0xA4 + address (addr 1 -> 0xA5).
  assign pi_rd_data   = 8'hA4 + {4'h0, pi_addr};
  assign b_pi_rd_data = 8'hA4 + {4'h0, b_pi_addr};

  uart_pi_arb #(.GAP_CYCLES(0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_ready(req0_ready), .req0_rvalid(req0_rvalid), .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_ready(req1_ready), .req1_rvalid(req1_rvalid), .req1_rdata(req1_rdata),
    .pi_blk_sel(pi_blk_sel), .pi_addr(pi_addr), .pi_wr_en(pi_wr_en), .pi_rd_en(pi_rd_en),
    .pi_wr_data(pi_wr_data), .pi_rd_data(pi_rd_data)
  );

  uart_pi_arb #(.GAP_CYCLES(4)) dut_gap (
    .clk(clk), .rst(rst),
    .req0_valid(b_req0_valid), .req0_we(b_req0_we), .req0_addr(b_req0_addr), .req0_wdata(b_req0_wdata),
    .req0_ready(b_req0_ready), .req0_rvalid(b_req0_rvalid), .req0_rdata(b_req0_rdata),
    .req1_valid(b_req1_valid), .req1_we(b_req1_we), .req1_addr(b_req1_addr), .req1_wdata(b_req1_wdata),
    .req1_ready(b_req1_ready), .req1_rvalid(b_req1_rvalid), .req1_rdata(b_req1_rdata),
    .pi_blk_sel(b_pi_blk_sel), .pi_addr(b_pi_addr), .pi_wr_en(b_pi_wr_en), .pi_rd_en(b_pi_rd_en),
    .pi_wr_data(b_pi_wr_data), .pi_rd_data(b_pi_rd_data)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         owner;
    bit         we;
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    int         acc;
  } exp_t;

  exp_t sq[$];      // expected strobes
  exp_t rq[$];      // expected completions
  int   acc_log[$]; // owner of each accepted command

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called just after a posedge; holds valid until accepted, then drops it.
  task automatic issue(input bit r, input bit w, input logic [3:0] a,
                       input logic [7:0] d, input bit exp_rsp);
    exp_t e;
    bit   got;
    got = 1'b0;
    e = '{owner: r, we: w, addr: a, wdata: d,
          rdata: (w ? 8'h00 : 8'hA4 + {4'h0, a}), acc: 0};
    if (r) begin req1_valid = 1'b1; req1_we = w; req1_addr = a; req1_wdata = d; end
    else   begin req0_valid = 1'b1; req0_we = w; req0_addr = a; req0_wdata = d; end
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (r ? req1_ready : req0_ready) begin
        got   = 1'b1;
        e.acc = cyc;
        sq.push_back(e);
        if (exp_rsp) rq.push_back(e);
        acc_log.push_back(int'(r));
      end
    end
    if (!got) chk("accept_timeout", 64'(got), 64'd1);
    @(posedge clk); #1;
    if (r) req1_valid = 1'b0; else req0_valid = 1'b0;
  endtask

  task automatic mon_rsp(input bit r, input logic [7:0] rd);
    exp_t e;
    if (rq.size() == 0) chk("unexpected_rvalid", 64'(rq.size()), 64'd1);
    else begin
      e = rq.pop_front();
      chk("rsp", {r, rd, 32'(cyc - e.acc)}, {e.owner, e.rdata, 32'd2});
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (pi_wr_en | pi_rd_en) begin
      chk("strobe_excl", 64'(pi_wr_en & pi_rd_en), 64'd0);
      if (sq.size() == 0) chk("unexpected_strobe", 64'(sq.size()), 64'd1);
      else begin
        e = sq.pop_front();
        chk("strobe", {pi_blk_sel, pi_addr, pi_wr_en, pi_rd_en,
                       (pi_wr_en ? pi_wr_data : 8'h00), 32'(cyc - e.acc)},
                      {1'b1, e.addr, e.we, !e.we, (e.we ? e.wdata : 8'h00), 32'd1});
      end
    end
    if (req0_ready | req1_ready) chk("ready_excl", 64'(req0_ready & req1_ready), 64'd0);
    if (req0_rvalid) mon_rsp(1'b0, req0_rdata);
    if (req1_rvalid) mon_rsp(1'b1, req1_rdata);
  end

  int b_last_acc = -1, b_last_strb = -1, b_acc = 0, b_strb = 0, b_rv = 0;
  always @(negedge clk) begin : mon_gap
    if (b_req0_ready) begin
      if (b_last_acc >= 0) chk("gap_grant_spacing", 64'(cyc - b_last_acc), 64'd7);
      b_last_acc = cyc;
      b_acc++;
    end
    if (b_pi_rd_en) begin
      if (b_last_strb >= 0) chk("gap_strobe_spacing", 64'(cyc - b_last_strb), 64'd7);
      b_last_strb = cyc;
      b_strb++;
    end
    if (b_req0_rvalid) begin
      b_rv++;
      chk("gap_rdata", 64'(b_req0_rdata), 64'hA7);
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [5:0] seq;
    rst = 1'b1;
    {req0_valid, req0_we, req0_addr, req0_wdata} = '0;
    {req1_valid, req1_we, req1_addr, req1_wdata} = '0;
    {b_req0_valid, b_req0_we, b_req0_wdata} = '0;
    {b_req1_valid, b_req1_we, b_req1_addr, b_req1_wdata} = '0;
    b_req0_addr = 4'h3;
    repeat (3) @(posedge clk);
    #1 req0_valid = 1'b1;
    @(negedge clk);
    chk("reset_state", {pi_blk_sel, pi_addr, pi_wr_en, pi_rd_en, pi_wr_data,
                        req0_ready, req1_ready, req0_rvalid, req1_rvalid,
                        req0_rdata, req1_rdata}, 64'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rst = 1'b0;

    // Single read: strobe at T+1, rvalid with 0xA5 at T+2.
    issue(1'b0, 1'b0, 4'h1, 8'h00, 1'b1);
    repeat (4) @(posedge clk); #1;
    chk("rdata0_hold", 64'(req0_rdata), 64'hA5);

    // Single write from requester 1 completes with zero data.
    issue(1'b1, 1'b1, 4'h2, 8'h3C, 1'b1);
    repeat (4) @(posedge clk); #1;
    chk("rdata1_write", 64'(req1_rdata), 64'h00);

    // Tie from reset: req0 first, then strict alternation.
    rst = 1'b1;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    acc_log.delete();
    fork
      begin
        issue(1'b0, 1'b0, 4'h4, 8'h00, 1'b1);
        issue(1'b0, 1'b1, 4'h5, 8'h11, 1'b1);
        issue(1'b0, 1'b0, 4'h6, 8'h00, 1'b1);
      end
      begin
        issue(1'b1, 1'b1, 4'h8, 8'h22, 1'b1);
        issue(1'b1, 1'b0, 4'h9, 8'h00, 1'b1);
        issue(1'b1, 1'b0, 4'hA, 8'h00, 1'b1);
      end
    join
    repeat (4) @(posedge clk); #1;
    chk("tie_count", 64'(acc_log.size()), 64'd6);
    seq = '0;
    for (int i = 0; i < 6 && i < acc_log.size(); i++) seq[i] = acc_log[i][0];
    chk("tie_order", 64'(seq), 64'(6'b101010));

    // A valid raised and dropped while busy never gets an access.
    fork
      issue(1'b0, 1'b0, 4'hB, 8'h00, 1'b1);
      begin
        @(posedge clk); #2;
        req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 4'hE; req1_wdata = 8'h77;
        @(negedge clk);
        chk("busy_no_ready", 64'(req1_ready), 64'd0);
        @(posedge clk); #2;
        req1_valid = 1'b0;
      end
    join
    repeat (4) @(posedge clk); #1;

    // Reset during ISSUE: strobe dies, no completion; re-issue completes.
    issue(1'b0, 1'b0, 4'h7, 8'h00, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_issue", {pi_blk_sel, pi_wr_en, pi_rd_en, req0_rvalid, req1_rvalid}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    issue(1'b0, 1'b0, 4'h7, 8'h00, 1'b1);
    repeat (4) @(posedge clk); #1;
    chk("rdata0_reissue", 64'(req0_rdata), 64'hAB);

    // Mixed traffic from both requesters with random spacing.
    fork
      for (int k = 0; k < 40; k++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1 issue(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 8'($urandom_range(0, 255)), 1'b1);
      end
      for (int k = 0; k < 40; k++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1 issue(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 8'($urandom_range(0, 255)), 1'b1);
      end
    join
    repeat (10) @(posedge clk); #1;
    chk("strobes_drained", 64'(sq.size()), 64'd0);
    chk("rsps_drained", 64'(rq.size()), 64'd0);

    // Gap instance: valid held high, accesses must be 7 cycles apart.
    b_req0_valid = 1'b1;
    repeat (30) @(posedge clk); #1;
    b_req0_valid = 1'b0;
    repeat (12) @(posedge clk); #1;
    chk("gap_counts", {32'(b_strb), 32'(b_rv)}, {32'(b_acc), 32'(b_acc)});
    chk("gap_accepts", 64'(b_acc >= 4), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
